div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 194 +++++++++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU group.
// A restoring radix-2 loop produces one quotient bit per cycle, so an accepted
// operation holds the pipeline for 33 cycles (acceptance + 32 iterations)
// and presents its result in the following cycle. Divide-by-zero and signed
// overflow bypass the loop and are answered combinationally in the same
// cycle that start is seen.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        divide/remainder instruction present in EXE (level)
//   op           funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend     rs1 operand
//   divisor      rs2 operand
//   flush        EXE-stage flush; kills any operation in flight
//   div_running  stall request to the stall/flush controller
//   valid        result valid this cycle
//   result       quotient or remainder selected by op
//
// State table
//   IDLE | waiting for start; special cases answered here
//   BUSY | 32 restoring iterations, counter 0..31
//   DONE | registered result presented for one cycle
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        div_running,
    output logic        valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_rem_q;
    logic        quo_neg_q;
    logic        rem_neg_q;
    logic [32:0] prem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [31:0] result_q;

    // ---------------------------------------------------------------------
    // Operand decode and special-case detection (IDLE only)
    // ---------------------------------------------------------------------
    logic        is_signed;
    logic        is_rem;
    logic        div_zero;
    logic        sgn_ovf;
    logic        special;
    logic        special_hit;
    logic        accept;
    logic [31:0] special_result;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        is_signed = ~op[0];
        is_rem    = op[1];
        div_zero  = (divisor == 32'd0);
        sgn_ovf   = is_signed && (dividend == 32'h8000_0000) &&
                    (divisor == 32'hFFFF_FFFF);
        special   = div_zero | sgn_ovf;

        special_hit = (state == IDLE) && start && !flush && special;
        accept      = (state == IDLE) && start && !flush && !special;

        if (div_zero)
            special_result = is_rem ? dividend : 32'hFFFF_FFFF;
        else
            special_result = is_rem ? 32'h0000_0000 : 32'h8000_0000;

        a_neg = is_signed & dividend[31];
        b_neg = is_signed & divisor[31];
        a_mag = a_neg ? (32'd0 - dividend) : dividend;
        b_mag = b_neg ? (32'd0 - divisor)  : divisor;
    end

    // ---------------------------------------------------------------------
    // One restoring iteration. quo starts as the dividend magnitude; its MSB
    // is shifted into the partial remainder while the new quotient bit is
    // shifted into its LSB, so after 32 steps it holds the quotient.
    // Because prem < dsr at all times, a non-negative difference always fits
    // in 32 bits and bit 32 of the difference is a clean borrow flag.
    // ---------------------------------------------------------------------
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [32:0] prem_nx;
    logic [31:0] quo_nx;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_result;

    always_comb begin
        shifted = {prem[31:0], quo[31]};
        diff    = shifted - {1'b0, dsr};
        if (diff[32]) begin
            prem_nx = shifted;
            quo_nx  = {quo[30:0], 1'b0};
        end else begin
            prem_nx = diff;
            quo_nx  = {quo[30:0], 1'b1};
        end

        quo_fix      = quo_neg_q ? (32'd0 - quo_nx) : quo_nx;
        rem_fix      = rem_neg_q ? (32'd0 - prem_nx[31:0]) : prem_nx[31:0];
        final_result = is_rem_q ? rem_fix : quo_fix;
    end

    // ---------------------------------------------------------------------
    // Control FSM and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            is_rem_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            prem      <= 33'd0;
            quo       <= 32'd0;
            dsr       <= 32'd0;
            result_q  <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BUSY;
                        cnt       <= 5'd0;
                        is_rem_q  <= is_rem;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        prem      <= 33'd0;
                        quo       <= a_mag;
                        dsr       <= b_mag;
                    end
                end
                BUSY: begin
                    prem <= prem_nx;
                    quo  <= quo_nx;
                    if (cnt == 5'd31) begin
                        state    <= DONE;
                        cnt      <= 5'd0;
                        result_q <= final_result;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    // start here is still the instruction just finished
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        div_running = accept || (state == BUSY);
        valid       = (state == DONE) || special_hit;
        if (state == DONE)
            result = result_q;
        else if (special_hit)
            result = special_result;
        else
            result = 32'd0;
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Directed bench for div_unit. A driver issues instructions the way the EXE
// stage does (start held while div_running, next instruction on the cycle
// after completion) and pushes the hand-computed result onto a queue; an
// independent monitor pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        div_running;
    logic        valid;
    logic [31:0] result;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .div_running (div_running),
        .valid       (valid),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every valid result against the scoreboard queue and
    // requires result == 0 on every other cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 result=%h expected no valid at %0t",
                         result, $time);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e);
            end
        end else begin
            check("idle_result_zero", result, 32'd0);
        end
    end

    // Issue one instruction and hold it in EXE until it completes.
    // lat is the expected number of cycles with div_running high before valid.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int run;
        bit got_valid;
        bit stop;
        run       = 0;
        got_valid = 1'b0;
        stop      = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        exp_q.push_back(exp);
        for (int c = 0; c < 100 && !stop; c++) begin
            @(negedge clk);
            if (valid) begin
                got_valid = 1'b1;
                stop      = 1'b1;
                check({name, " running_at_valid"}, {31'd0, div_running}, 32'd0);
            end else if (div_running) begin
                run++;
                @(posedge clk);
                #1;
                // operands must be ignored once the divide is accepted
                dividend = ~dividend;
                divisor  = divisor ^ 32'h5A5A_5A5A;
            end else begin
                stop = 1'b1;
            end
        end
        check({name, " valid_seen"}, {31'd0, got_valid}, 32'd1);
        check({name, " latency"}, 32'(run), 32'(lat));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        dividend = 32'd0;
        divisor  = 32'd0;
        flush    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset div_running", {31'd0, div_running}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        // Back-to-back sequence, start held continuously across instructions
        run_op(OP_DIVU, 32'd100,        32'd7,          32'd14,         33, "divu_100_7");
        run_op(OP_REMU, 32'd100,        32'd7,          32'd2,          33, "remu_100_7");
        run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2");
        run_op(OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2");
        run_op(OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "div_7_m2");
        run_op(OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, "rem_7_m2");
        run_op(OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  0,  "divu_by0");
        run_op(OP_REM,  32'd5,          32'd0,          32'd5,          0,  "rem_5_by0");
        run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  "div_ovf");
        run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  "rem_ovf");
        run_op(OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, "divu_big");
        run_op(OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, "remu_big");
        run_op(OP_DIV,  32'hFFFF_FFEC,  32'hFFFF_FFFA,  32'd3,          33, "div_m20_m6");
        run_op(OP_REM,  32'hFFFF_FFEC,  32'hFFFF_FFFA,  32'hFFFF_FFFE,  33, "rem_m20_m6");
        run_op(OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  33, "div_min_1");
        run_op(OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, "divu_max_1");
        run_op(OP_DIV,  32'd0,          32'd0,          32'hFFFF_FFFF,  0,  "div_0_by0");
        run_op(OP_REMU, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF,  0,  "remu_by0");
        run_op(OP_DIVU, 32'd1000,       32'd10,         32'd100,        33, "divu_after_special");

        // Flush during BUSY cycle 10: operation dies without a valid pulse
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle running", {31'd0, div_running}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("after_flush running", {31'd0, div_running}, 32'd0);
        check("after_flush valid", {31'd0, valid}, 32'd0);
        repeat (40) @(posedge clk);
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3_after_flush");

        // Reset during BUSY cycle 20
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = OP_DIV;
        dividend = 32'hFFFF_FF9C;
        divisor  = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("midrst div_running", {31'd0, div_running}, 32'd0);
        check("midrst valid", {31'd0, valid}, 32'd0);
        check("midrst result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        // -100 / 7 = -14 rem -2
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, "div_after_rst");
        run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, "rem_after_rst");

        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
